y_unload_buffer: RTL and testbench
==================================

// Module: y_unload_buffer
// PURPOSE
//  Output-side counterpart of the X operand loader: collects per-cycle results from the
//  three PE rows of the matrix array and packs them into WORD_W words. Words are streamed
//  out over a valid/ready handshake for write-back to memory.
//  Sits between the PE array result taps and the result-memory write port.
// PARAMETERS
//  DATA_W  16  width of one result per row (bits)
//  COLS    4   results captured per row before a drain; COLS*DATA_W must be a multiple of WORD_W
//  WORD_W  32  output word width (bits)
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  res_valid  in   1        res1..res3 hold one valid result column this cycle
//  res_ready  out  1        buffer accepts a result column this cycle
//  res1       in   DATA_W   PE row 1 result
//  res2       in   DATA_W   PE row 2 result
//  res3       in   DATA_W   PE row 3 result
//  flush      in   1        end-of-row strobe: drain early, zero-padding missing columns
//  out_valid  out  1        out_data holds a valid packed word
//  out_ready  in   1        downstream accepts out_data
//  out_data   out  WORD_W   packed result word
//  out_last   out  1        final word of a drain (only with Y_BUF_LAST_EN)
//  busy       out  1        high in DRAIN or with fill_cnt != 0
// BEHAVIOUR
//  - Reset: state=FILL, fill_cnt=0, word_cnt=0, lane regs=0; res_ready=1, out_valid=0,
//    out_data=0, out_last=0, busy=0. A reset mid-drain discards all buffered data.
//  - Storage: three lane regs L1..L3, COLS*DATA_W bits each.
//    Column k (0 = first accepted) occupies bits [k*DATA_W +: DATA_W].
//  - FILL: res_ready=1, out_valid=0. A column is accepted when res_valid && res_ready.
//    On accept, res1..res3 are written to slot fill_cnt of L1..L3 and fill_cnt increments.
//    The accept that reaches fill_cnt=COLS moves the block to DRAIN on the next cycle.
//  - flush in FILL with fill_cnt>0: unwritten slots read as 0; go to DRAIN next cycle.
//    A column accepted in the same cycle as flush is stored first, then the block drains.
//    flush with fill_cnt=0 and no accept in that cycle is ignored.
//  - DRAIN: res_ready=0; any res_valid is ignored and its data is not stored.
//    WPL = COLS*DATA_W/WORD_W words per lane, emitted in order:
//      L1 word0..WPL-1, then L2, then L3.
//    Word j of a lane = lane[j*WORD_W +: WORD_W].
//    out_valid=1. out_data must hold steady while out_valid && !out_ready.
//    word_cnt advances only on out_valid && out_ready.
//    The handshake on word 3*WPL-1 moves the block to FILL on the next cycle, clears
//    fill_cnt, word_cnt and the lane regs, and raises res_ready in that same cycle.
//  - Registered outputs, no combinational path from input to output:
//    first word is visible the cycle after entering DRAIN; 1 word/cycle at out_ready=1.
//    Drain length = 3*WPL cycles minimum (6 for defaults).
//  - flush during DRAIN is ignored. busy=1 from the first accept until return to FILL.
// CONFIGURATION
//  Y_BUF_LAST_EN defined: out_last port exists and =1 together with out_valid on word
//    3*WPL-1 only; 0 otherwise.
//  Not defined: out_last port is absent; all other behaviour is identical.
// TESTING
//  1. Reset, then 4 back-to-back columns, row r column k = 16'h0r0k, out_ready=1 ->
//     6 words 32'h0101_0100, 32'h0103_0102, 32'h0201_0200, 32'h0203_0202,
//     32'h0301_0300, 32'h0303_0302; res_ready=0 for exactly 6 cycles.
//  2. As 1 with out_ready toggling 1,0,0,1,... -> out_data held stable while stalled;
//     no word lost or duplicated; 6 handshakes total.
//  3. 2 columns (16'hAAAA, 16'hBBBB on all rows), then flush ->
//     each lane gives 32'hBBBB_AAAA, 32'h0000_0000.
//  4. 3 columns, flush asserted with the 4th column in the same cycle -> full 4-column
//     drain; res_valid during DRAIN with 16'hFFFF -> value absent from output,
//     next FILL starts at slot 0.
//  5. rst pulsed after 3 of 6 words -> next cycle out_valid=0, res_ready=1, busy=0;
//     a fresh fill produces correct words with no stale data.
//  6. Y_BUF_LAST_EN defined, scenario 1 -> out_last=1 on the 6th word only.
//     Undefined -> module elaborates without the port.

Source files
------------

// File: rtl/y_unload_buffer.sv
// y_unload_buffer: result-side packer for the three PE rows of the matrix array.
// Captures one result column per accepted cycle into three lane registers. When COLS
// columns have been captured, or on an early flush, it drains the lanes as WORD_W words
// over a valid/ready stream in lane order L1, L2, L3.
// Optional feature macro: Y_BUF_LAST_EN adds the out_last port, which marks the final
// word of each drain.
module y_unload_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COLS   = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res1,
  input  logic [DATA_W-1:0] res2,
  input  logic [DATA_W-1:0] res3,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
`ifdef Y_BUF_LAST_EN
  output logic              out_last,
`endif
  output logic              busy
);

  localparam int unsigned LaneW    = COLS * DATA_W;
  localparam int unsigned Wpl      = LaneW / WORD_W;
  localparam int unsigned NumWords = 3 * Wpl;
  localparam int unsigned FillW    = $clog2(COLS + 1);
  localparam int unsigned WordW    = (NumWords > 1) ? $clog2(NumWords) : 1;

  localparam logic [FillW-1:0] FillFull = FillW'(COLS);
  localparam logic [WordW-1:0] LastWord = WordW'(NumWords - 1);

  // A lane must split into whole output words.
  if ((LaneW % WORD_W) != 0 || Wpl == 0) begin : g_bad_cfg
    $error("y_unload_buffer: COLS*DATA_W must be a non-zero multiple of WORD_W");
  end

  typedef enum logic [0:0] {
    StFill,
    StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [FillW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [WordW-1:0]   word_cnt_q, word_cnt_d;
  logic [LaneW-1:0]   lane1_q, lane1_d;
  logic [LaneW-1:0]   lane2_q, lane2_d;
  logic [LaneW-1:0]   lane3_q, lane3_d;

  // Output registers, loaded from next-state so outputs never see inputs combinationally.
  logic               res_ready_q;
  logic               out_valid_q;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic               busy_q;

  logic               accept;
  logic [3*LaneW-1:0] all_lanes_d;

  assign accept = res_valid && (state_q == StFill);

  // Next-state: column capture in FILL, word sequencing in DRAIN.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    word_cnt_d = word_cnt_q;
    lane1_d    = lane1_q;
    lane2_d    = lane2_q;
    lane3_d    = lane3_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          for (int k = 0; k < COLS; k++) begin
            if (fill_cnt_q == FillW'(k)) begin
              lane1_d[k*DATA_W +: DATA_W] = res1;
              lane2_d[k*DATA_W +: DATA_W] = res2;
              lane3_d[k*DATA_W +: DATA_W] = res3;
            end
          end
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
        // Flush on an empty buffer (no accept this cycle) is a no-op; slots never
        // written still hold the zeros left by the previous clear.
        if ((fill_cnt_d == FillFull) || (flush && (fill_cnt_d != '0))) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (out_ready) begin
          if (word_cnt_q == LastWord) begin
            state_d    = StFill;
            fill_cnt_d = '0;
            word_cnt_d = '0;
            lane1_d    = '0;
            lane2_d    = '0;
            lane3_d    = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Word j of the concatenation {L3, L2, L1} is exactly the j-th word of the drain order.
  assign all_lanes_d = {lane3_d, lane2_d, lane1_d};

  // Select the word that will be presented in the next cycle.
  always_comb begin
    out_data_d = '0;
    if (state_d == StDrain) begin
      for (int w = 0; w < NumWords; w++) begin
        if (word_cnt_d == WordW'(w)) begin
          out_data_d = all_lanes_d[w*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      word_cnt_q <= '0;
      lane1_q    <= '0;
      lane2_q    <= '0;
      lane3_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      word_cnt_q <= word_cnt_d;
      lane1_q    <= lane1_d;
      lane2_q    <= lane2_d;
      lane3_q    <= lane3_d;
    end
  end

  // Registered outputs; out_data is stable while stalled because nothing in its
  // next-state changes without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      res_ready_q <= (state_d == StFill);
      out_valid_q <= (state_d == StDrain);
      out_data_q  <= out_data_d;
      busy_q      <= (state_d == StDrain) || (fill_cnt_d != '0);
    end
  end

  assign res_ready = res_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef Y_BUF_LAST_EN
  logic out_last_q;

  // Flag the final word of the drain alongside out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_last_q <= 1'b0;
    end else begin
      out_last_q <= (state_d == StDrain) && (word_cnt_d == LastWord);
    end
  end

  assign out_last = out_last_q;
`endif

endmodule

// File: tb/tb_y_unload_buffer.sv
// Bench for y_unload_buffer: a fixed vector table with literal expected outputs, hand-written
// corner-case sequences and a randomized phase, all checked every cycle against a
// column/word-list reference model. Build with Y_BUF_LAST_EN defined to check out_last.
module tb_y_unload_buffer;

  localparam int DATA_W = 16;
  localparam int COLS   = 4;
  localparam int WORD_W = 32;
  localparam int CPW    = WORD_W / DATA_W;
  localparam int WPL    = COLS / CPW;
  localparam int NWORDS = 3 * WPL;

  logic              clk = 1'b0;
  logic              rst;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res1, res2, res3;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              busy;
`ifdef Y_BUF_LAST_EN
  logic              out_last;
`endif

  y_unload_buffer #(
    .DATA_W(DATA_W),
    .COLS  (COLS),
    .WORD_W(WORD_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res1     (res1),
    .res2     (res2),
    .res3     (res3),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
`ifdef Y_BUF_LAST_EN
    .out_last (out_last),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hs    = 0;

  // Reference model: captured columns, and the word list of the drain in progress.
  logic [DATA_W-1:0] m_col [COLS][3];
  int                m_fill  = 0;
  bit                m_drain = 1'b0;
  int                m_widx  = 0;
  logic [WORD_W-1:0] m_words [$];

  function automatic void m_clear();
    for (int k = 0; k < COLS; k++)
      for (int r = 0; r < 3; r++) m_col[k][r] = '0;
    m_fill  = 0;
    m_drain = 1'b0;
    m_widx  = 0;
    m_words.delete();
  endfunction

  // Row r, word j packs columns j*CPW .. j*CPW+CPW-1, earliest column in the low bits.
  function automatic void m_build();
    logic [WORD_W-1:0] w;
    m_words.delete();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < WPL; j++) begin
        w = '0;
        for (int c = 0; c < CPW; c++)
          w = w | (WORD_W'(m_col[j*CPW + c][r]) << (c * DATA_W));
        m_words.push_back(w);
      end
    end
  endfunction

  function automatic void m_step(bit r, bit rv, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                                 logic [DATA_W-1:0] c, bit fl, bit ordy);
    if (r) begin
      m_clear();
    end else if (!m_drain) begin
      if (rv) begin
        m_col[m_fill][0] = a;
        m_col[m_fill][1] = b;
        m_col[m_fill][2] = c;
        m_fill++;
      end
      if (m_fill == COLS || (fl && m_fill > 0)) begin
        m_build();
        m_drain = 1'b1;
        m_widx  = 0;
      end
    end else if (ordy) begin
      m_widx++;
      if (m_widx == NWORDS) m_clear();
    end
  endfunction

  function automatic void chk(string nm, logic [WORD_W-1:0] act, logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_model(string tag);
    chk({tag, " res_ready"}, {31'b0, res_ready}, {31'b0, !m_drain});
    chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, m_drain});
    chk({tag, " out_data"}, out_data, m_drain ? m_words[m_widx] : '0);
    chk({tag, " busy"}, {31'b0, busy}, {31'b0, m_drain || (m_fill != 0)});
`ifdef Y_BUF_LAST_EN
    chk({tag, " out_last"}, {31'b0, out_last}, {31'b0, m_drain && (m_widx == NWORDS - 1)});
`endif
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, compare after the
  // next rising edge at the following falling edge.
  task automatic tick(string tag, bit r, bit rv, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                      logic [DATA_W-1:0] c, bit fl, bit ordy);
    rst       = r;
    res_valid = rv;
    res1      = a;
    res2      = b;
    res3      = c;
    flush     = fl;
    out_ready = ordy;
    if (!r && out_valid && ordy) hs++;
    m_step(r, rv, a, b, c, fl, ordy);
    @(posedge clk);
    @(negedge clk);
    chk_model(tag);
  endtask

  typedef struct {
    bit                rst;
    bit                rv;
    logic [DATA_W-1:0] r1, r2, r3;
    bit                fl;
    bit                ordy;
    bit                e_ready;
    bit                e_valid;
    logic [WORD_W-1:0] e_data;
    bit                e_busy;
    bit                e_last;
  } vec_t;

  vec_t vt [$];

  function automatic void add(bit r, bit rv, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                              logic [DATA_W-1:0] c, bit fl, bit ordy, bit er, bit ev,
                              logic [WORD_W-1:0] ed, bit eb, bit el);
    vt.push_back('{r, rv, a, b, c, fl, ordy, er, ev, ed, eb, el});
  endfunction

  initial begin
    logic [WORD_W-1:0] s1w [6];
    logic [WORD_W-1:0] s3w [6];
    int                rdy0;

    s1w = '{32'h0101_0100, 32'h0103_0102, 32'h0201_0200,
            32'h0203_0202, 32'h0301_0300, 32'h0303_0302};
    s3w = '{32'hBBBB_AAAA, 32'h0000_0000, 32'hBBBB_AAAA,
            32'h0000_0000, 32'hBBBB_AAAA, 32'h0000_0000};

    // Table: reset, full 4-column fill and drain, then a 2-column flush drain.
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 16'(16'h0100 + k), 16'(16'h0200 + k), 16'(16'h0300 + k), 0, 1,
          1, 0, 32'h0, 1, 0);
    add(0, 1, 16'h0103, 16'h0203, 16'h0303, 0, 1, 0, 1, s1w[0], 1, 0);
    for (int j = 1; j < 6; j++) add(0, 0, 0, 0, 0, 0, 1, 0, 1, s1w[j], 1, j == 5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0, 0);
    add(0, 1, 16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 1, 1, 0, 32'h0, 1, 0);
    add(0, 1, 16'hBBBB, 16'hBBBB, 16'hBBBB, 0, 1, 1, 0, 32'h0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1, s3w[0], 1, 0);
    for (int j = 1; j < 6; j++) add(0, 0, 0, 0, 0, 0, 1, 0, 1, s3w[j], 1, j == 5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0, 0);

    rst = 1'b1; res_valid = 1'b0; res1 = '0; res2 = '0; res3 = '0;
    flush = 1'b0; out_ready = 1'b0;
    m_clear();
    @(negedge clk);

    rdy0 = 0;
    foreach (vt[i]) begin
      tick($sformatf("vec%0d", i), vt[i].rst, vt[i].rv, vt[i].r1, vt[i].r2, vt[i].r3,
           vt[i].fl, vt[i].ordy);
      if (!res_ready) rdy0++;
      chk($sformatf("vec%0d tbl res_ready", i), {31'b0, res_ready}, {31'b0, vt[i].e_ready});
      chk($sformatf("vec%0d tbl out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("vec%0d tbl out_data", i), out_data, vt[i].e_data);
      chk($sformatf("vec%0d tbl busy", i), {31'b0, busy}, {31'b0, vt[i].e_busy});
`ifdef Y_BUF_LAST_EN
      chk($sformatf("vec%0d tbl out_last", i), {31'b0, out_last}, {31'b0, vt[i].e_last});
`endif
    end
    chk("res_ready low cycles", 32'(rdy0), 32'd12);

    // Stalled drain: out_ready pattern 1,0,0,1,... must give exactly 6 handshakes.
    for (int k = 0; k < 4; k++)
      tick("s2 fill", 0, 1, 16'(16'h0100 + k), 16'(16'h0200 + k), 16'(16'h0300 + k), 0, 0);
    hs = 0;
    for (int i = 0; i < 16; i++) tick("s2 drain", 0, 0, 0, 0, 0, 0, (i % 3) == 0);
    chk("s2 handshakes", 32'(hs), 32'd6);

    // Flush together with the 4th column; res_valid junk during the drain is dropped.
    for (int k = 0; k < 3; k++)
      tick("s4 fill", 0, 1, 16'(16'h1000 + k), 16'(16'h2000 + k), 16'(16'h3000 + k), 0, 1);
    tick("s4 last+flush", 0, 1, 16'h1003, 16'h2003, 16'h3003, 1, 1);
    for (int i = 0; i < 6; i++) tick("s4 drain", 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1);
    tick("s4 refill", 0, 1, 16'h0042, 16'h0043, 16'h0044, 1, 1);
    for (int i = 0; i < 6; i++) tick("s4 drain2", 0, 0, 0, 0, 0, 0, 1);

    // Flush on an empty buffer is ignored.
    tick("empty flush", 0, 0, 0, 0, 0, 1, 1);
    chk("empty flush out_valid", {31'b0, out_valid}, 32'd0);

    // Reset mid-drain discards buffered data.
    for (int k = 0; k < 4; k++)
      tick("s5 fill", 0, 1, 16'(16'h5550 + k), 16'(16'h6660 + k), 16'(16'h7770 + k), 0, 1);
    for (int i = 0; i < 3; i++) tick("s5 drain", 0, 0, 0, 0, 0, 0, 1);
    tick("s5 rst", 1, 0, 0, 0, 0, 0, 1);
    chk("s5 out_valid", {31'b0, out_valid}, 32'd0);
    chk("s5 res_ready", {31'b0, res_ready}, 32'd1);
    chk("s5 busy", {31'b0, busy}, 32'd0);
    tick("s5 fresh", 0, 1, 16'h00C1, 16'h00C2, 16'h00C3, 1, 1);
    for (int i = 0; i < 6; i++) tick("s5 drain2", 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick("rand", ($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
           16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
